// File: rtl/rf_sequencer.sv
// rf_sequencer: multi-cycle command sequencer driving an external
// register file through a small ALU (MOV / ADD / AND / MVN).
module rf_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [2:0]       cmd_rd,
  input  logic [2:0]       cmd_rn,
  input  logic [2:0]       cmd_rm,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [2:0]       rf_readnum,
  input  logic [WIDTH-1:0] rf_data_out,
  output logic [2:0]       rf_writenum,
  output logic             rf_write,
  output logic [WIDTH-1:0] rf_data_in,
  output logic             done,
  output logic [2:0]       status
);

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC,
    S_WRITE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [1:0]       r_op;
  logic [2:0]       r_rd;
  logic [2:0]       r_rn;
  logic [2:0]       r_rm;
  logic [WIDTH-1:0] r_imm;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_c;
  logic [2:0]       r_status;
  logic             r_done;
  logic [WIDTH-1:0] r_data_in;

  logic             w_accept;
  logic [WIDTH-1:0] w_result;
  logic             w_v;
  logic             w_n;
  logic             w_z;

  assign w_accept = cmd_valid && (r_state == S_IDLE);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode; the entry point depends on the incoming opcode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          unique case (cmd_op)
            OP_MOV:  w_next = S_WRITE;
            OP_MVN:  w_next = S_LOAD_B;
            default: w_next = S_LOAD_A;
          endcase
        end
      end
      S_LOAD_A: w_next = S_LOAD_B;
      S_LOAD_B: w_next = S_EXEC;
      S_EXEC:   w_next = S_WRITE;
      S_WRITE:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Moore outputs toward the command port and register file
  always_comb begin
    cmd_ready   = 1'b0;
    rf_readnum  = 3'd0;
    rf_writenum = 3'd0;
    rf_write    = 1'b0;
    unique case (r_state)
      S_IDLE:   cmd_ready  = 1'b1;
      S_LOAD_A: rf_readnum = r_rn;
      S_LOAD_B: rf_readnum = r_rm;
      S_WRITE: begin
        rf_write    = 1'b1;
        rf_writenum = r_rd;
      end
      default: ;
    endcase
  end

  // Command capture, only on an accepted handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op  <= OP_MOV;
      r_rd  <= 3'd0;
      r_rn  <= 3'd0;
      r_rm  <= 3'd0;
      r_imm <= '0;
    end else if (w_accept) begin
      r_op  <= cmd_op;
      r_rd  <= cmd_rd;
      r_rn  <= cmd_rn;
      r_rm  <= cmd_rm;
      r_imm <= cmd_imm;
    end
  end

  // ALU and flag computation from the operand registers
  always_comb begin
    w_result = '0;
    w_v      = 1'b0;
    unique case (r_op)
      OP_ADD: begin
        w_result = r_a + r_b;
        w_v = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
              (w_result[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_AND:  w_result = r_a & r_b;
      OP_MVN:  w_result = ~r_b;
      default: w_result = '0;
    endcase
    w_n = w_result[WIDTH-1];
    w_z = (w_result == '0);
  end

  // Operand and result registers; status moves only on EXEC
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_status <= 3'b000;
    end else begin
      if (r_state == S_LOAD_A) r_a <= rf_data_out;
      if (r_state == S_LOAD_B) r_b <= rf_data_out;
      if (r_state == S_EXEC) begin
        r_c      <= w_result;
        r_status <= {w_n, w_v, w_z};
      end
    end
  end

  // Write data is loaded on the edge entering WRITE and then held
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_in <= '0;
    end else if (w_accept && cmd_op == OP_MOV) begin
      r_data_in <= cmd_imm;
    end else if (r_state == S_EXEC) begin
      r_data_in <= w_result;
    end
  end

  // Completion pulse in the cycle following WRITE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_done <= 1'b0;
    else          r_done <= (r_state == S_WRITE);
  end

  assign rf_data_in = r_data_in;
  assign done       = r_done;
  assign status     = r_status;

endmodule

// File: tb/tb_rf_sequencer.sv
// tb_rf_sequencer: directed checks of rf_sequencer against a
// behavioural register file and hand-computed expected values.
module tb_rf_sequencer;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_rd;
  logic [2:0]  cmd_rn;
  logic [2:0]  cmd_rm;
  logic [15:0] cmd_imm;
  logic [2:0]  rf_readnum;
  logic [15:0] rf_data_out;
  logic [2:0]  rf_writenum;
  logic        rf_write;
  logic [15:0] rf_data_in;
  logic        done;
  logic [2:0]  status;

  logic [15:0] rf_m [8];
  int          wr_cnt;
  int          done_cnt;
  int          n_vec;
  int          n_err;

  rf_sequencer #(.WIDTH(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_rd      (cmd_rd),
    .cmd_rn      (cmd_rn),
    .cmd_rm      (cmd_rm),
    .cmd_imm     (cmd_imm),
    .rf_readnum  (rf_readnum),
    .rf_data_out (rf_data_out),
    .rf_writenum (rf_writenum),
    .rf_write    (rf_write),
    .rf_data_in  (rf_data_in),
    .done        (done),
    .status      (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rf_data_out = rf_m[rf_readnum];

  always @(posedge clk) begin
    if (rf_write) begin
      rf_m[rf_writenum] <= rf_data_in;
      wr_cnt <= wr_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic run_mov(input logic [2:0] rd, input logic [15:0] imm);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_rd = rd; cmd_imm = imm;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'b00;
    cmd_rd = 3'd0; cmd_rn = 3'd0; cmd_rm = 3'd0; cmd_imm = 16'h0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (cmd_ready !== 1'b1 || rf_write !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctl: ready=%b write=%b done=%b want 1 0 0",
               cmd_ready, rf_write, done);
    end
    n_vec++;
    if (rf_readnum !== 3'd0 || rf_writenum !== 3'd0 ||
        rf_data_in !== 16'h0 || status !== 3'b000) begin
      n_err++;
      $display("FAIL reset_dat: rn=%0d wn=%0d din=%h st=%b want 0 0 0 000",
               rf_readnum, rf_writenum, rf_data_in, status);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_mov;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_rd = 3'd3; cmd_imm = 16'h0042;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_vec++;
    if (rf_write !== 1'b1 || rf_writenum !== 3'd3 ||
        rf_data_in !== 16'h0042 || cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL mov_write: w=%b wn=%0d d=%h rdy=%b want 1 3 0042 0",
               rf_write, rf_writenum, rf_data_in, cmd_ready);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || status !== 3'b000 || rf_m[3] !== 16'h0042) begin
      n_err++;
      $display("FAIL mov_done: done=%b st=%b r3=%h want 1 000 0042",
               done, status, rf_m[3]);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || rf_write !== 1'b0 || rf_data_in !== 16'h0042) begin
      n_err++;
      $display("FAIL mov_after: done=%b w=%b d=%h want 0 0 0042",
               done, rf_write, rf_data_in);
    end
  endtask

  task automatic test_add;
    run_mov(3'd1, 16'h7FFF);
    run_mov(3'd2, 16'h0001);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01;
    cmd_rd = 3'd0; cmd_rn = 3'd1; cmd_rm = 3'd2; cmd_imm = 16'hDEAD;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_vec++;
    if (rf_readnum !== 3'd1 || cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL add_loada: rn=%0d rdy=%b want 1 0", rf_readnum, cmd_ready);
    end
    @(negedge clk);
    n_vec++;
    if (rf_readnum !== 3'd2) begin
      n_err++;
      $display("FAIL add_loadb: rn=%0d want 2", rf_readnum);
    end
    @(negedge clk);
    n_vec++;
    if (rf_readnum !== 3'd0 || rf_write !== 1'b0) begin
      n_err++;
      $display("FAIL add_exec: rn=%0d w=%b want 0 0", rf_readnum, rf_write);
    end
    @(negedge clk);
    n_vec++;
    if (rf_write !== 1'b1 || rf_writenum !== 3'd0 || rf_data_in !== 16'h8000) begin
      n_err++;
      $display("FAIL add_write: w=%b wn=%0d d=%h want 1 0 8000",
               rf_write, rf_writenum, rf_data_in);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || status !== 3'b110 || rf_m[0] !== 16'h8000) begin
      n_err++;
      $display("FAIL add_done: done=%b st=%b r0=%h want 1 110 8000",
               done, status, rf_m[0]);
    end
  endtask

  task automatic test_and;
    run_mov(3'd4, 16'h00FF);
    run_mov(3'd5, 16'hFF00);
    run_mov(3'd6, 16'h1234);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10;
    cmd_rd = 3'd6; cmd_rn = 3'd4; cmd_rm = 3'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (status !== 3'b110) begin
      n_err++;
      $display("FAIL and_status_hold: st=%b want 110", status);
    end
    @(negedge clk);
    n_vec++;
    if (rf_write !== 1'b1 || rf_writenum !== 3'd6 || rf_data_in !== 16'h0000) begin
      n_err++;
      $display("FAIL and_write: w=%b wn=%0d d=%h want 1 6 0000",
               rf_write, rf_writenum, rf_data_in);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || status !== 3'b001 || rf_m[6] !== 16'h0000) begin
      n_err++;
      $display("FAIL and_done: done=%b st=%b r6=%h want 1 001 0000",
               done, status, rf_m[6]);
    end
  endtask

  task automatic test_mvn;
    run_mov(3'd7, 16'h0000);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b11;
    cmd_rd = 3'd7; cmd_rn = 3'd5; cmd_rm = 3'd7;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_rd = 3'd2; cmd_rm = 3'd4;
    n_vec++;
    if (rf_readnum !== 3'd7) begin
      n_err++;
      $display("FAIL mvn_loadb: rn=%0d want 7", rf_readnum);
    end
    @(negedge clk);
    n_vec++;
    if (rf_readnum !== 3'd0 || rf_write !== 1'b0) begin
      n_err++;
      $display("FAIL mvn_exec: rn=%0d w=%b want 0 0", rf_readnum, rf_write);
    end
    @(negedge clk);
    n_vec++;
    if (rf_write !== 1'b1 || rf_writenum !== 3'd7 || rf_data_in !== 16'hFFFF) begin
      n_err++;
      $display("FAIL mvn_write: w=%b wn=%0d d=%h want 1 7 ffff",
               rf_write, rf_writenum, rf_data_in);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || status !== 3'b100 || rf_m[7] !== 16'hFFFF) begin
      n_err++;
      $display("FAIL mvn_done: done=%b st=%b r7=%h want 1 100 ffff",
               done, status, rf_m[7]);
    end
  endtask

  task automatic test_reset_mid;
    int w0;
    int d0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01;
    cmd_rd = 3'd3; cmd_rn = 3'd1; cmd_rm = 3'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    w0 = wr_cnt;
    d0 = done_cnt;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (rf_write !== 1'b0 || done !== 1'b0 || status !== 3'b000 ||
        rf_data_in !== 16'h0 || rf_readnum !== 3'd0 || cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_async: w=%b done=%b st=%b d=%h rn=%0d rdy=%b want 0 0 000 0000 0 1",
               rf_write, done, status, rf_data_in, rf_readnum, cmd_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (wr_cnt !== w0 || done_cnt !== d0 || rf_m[3] !== 16'h0042 ||
        cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_abort: writes=%0d dones=%0d r3=%h rdy=%b want %0d %0d 0042 1",
               wr_cnt - w0, done_cnt - d0, rf_m[3], cmd_ready, 0, 0);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_rd = 3'd2; cmd_imm = 16'h1111;
    @(negedge clk);
    cmd_rd = 3'd3; cmd_imm = 16'h2222;
    n_vec++;
    if (cmd_ready !== 1'b0 || rf_write !== 1'b1 || rf_data_in !== 16'h1111) begin
      n_err++;
      $display("FAIL b2b_first: rdy=%b w=%b d=%h want 0 1 1111",
               cmd_ready, rf_write, rf_data_in);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || cmd_ready !== 1'b1 || rf_write !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_donecyc: done=%b rdy=%b w=%b want 1 1 0",
               done, cmd_ready, rf_write);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    n_vec++;
    if (rf_write !== 1'b1 || rf_writenum !== 3'd3 ||
        rf_data_in !== 16'h2222 || cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_second: w=%b wn=%0d d=%h rdy=%b want 1 3 2222 0",
               rf_write, rf_writenum, rf_data_in, cmd_ready);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || rf_m[2] !== 16'h1111 || rf_m[3] !== 16'h2222) begin
      n_err++;
      $display("FAIL b2b_regs: done=%b r2=%h r3=%h want 1 1111 2222",
               done, rf_m[2], rf_m[3]);
    end
  endtask

  task automatic test_idle_hold;
    cmd_op = 2'b01; cmd_rd = 3'd5; cmd_rn = 3'd6; cmd_rm = 3'd7;
    cmd_imm = 16'hBEEF;
    repeat (3) @(negedge clk);
    n_vec++;
    if (cmd_ready !== 1'b1 || rf_write !== 1'b0 || done !== 1'b0 ||
        rf_readnum !== 3'd0 || rf_data_in !== 16'h2222 || status !== 3'b000) begin
      n_err++;
      $display("FAIL idle_hold: rdy=%b w=%b done=%b rn=%0d d=%h st=%b want 1 0 0 0 2222 000",
               cmd_ready, rf_write, done, rf_readnum, rf_data_in, status);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    wr_cnt = 0;
    done_cnt = 0;
    test_reset();
    test_mov();
    test_add();
    test_and();
    test_mvn();
    test_reset_mid();
    test_back_to_back();
    test_idle_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rf_sequencer.md
RF_SEQUENCER -- requirements
Module: rf_sequencer

Interface
REQ-001 Parameter: WIDTH, 16, data width of register file, immediate and ALU path.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: reset_n  in  1  asynchronous active-low reset.
REQ-005 Port: cmd_valid  in  1  command present.
REQ-006 Port: cmd_ready  out  1  sequencer can accept a command.
REQ-007 Port: cmd_op  in  2  opcode: 00 MOV imm, 01 ADD, 10 AND, 11 MVN.
REQ-008 Port: cmd_rd / cmd_rn / cmd_rm  in  3 each  destination / source A / source B register numbers.
REQ-009 Port: cmd_imm  in  WIDTH  immediate for MOV.
REQ-010 Port: rf_readnum  out  3  register-file read select.
REQ-011 Port: rf_data_out  in  WIDTH  register-file combinational read data.
REQ-012 Port: rf_writenum  out  3  register-file write select.
REQ-013 Port: rf_write  out  1  register-file write enable.
REQ-014 Port: rf_data_in  out  WIDTH  register-file write data.
REQ-015 Port: done  out  1  one-cycle completion pulse.
REQ-016 Port: status  out  3  {N, V, Z} flags of last ALU op.

Function
REQ-017 States SHALL be IDLE, LOAD_A, LOAD_B, EXEC, WRITE.
REQ-018 cmd_ready SHALL be 1 only in IDLE, combinationally.
REQ-019 Command accepted on rising edge with cmd_valid=1 and cmd_ready=1; op, rd, rn, rm, imm latched at that edge; inputs ignored otherwise.
REQ-020 Transitions: MOV IDLE->WRITE; ADD/AND IDLE->LOAD_A->LOAD_B->EXEC->WRITE; MVN IDLE->LOAD_B->EXEC->WRITE; WRITE->IDLE always.
REQ-021 LOAD_A: rf_readnum=latched rn; register A captures rf_data_out at end of cycle.
REQ-022 LOAD_B: rf_readnum=latched rm; register B captures rf_data_out at end of cycle.
REQ-023 rf_readnum SHALL be 0 in IDLE, EXEC, WRITE.
REQ-024 EXEC: C <= A+B (ADD, mod 2^WIDTH), A&B (AND), ~B (MVN); status updated same edge.
REQ-025 Z = (result==0); N = result[WIDTH-1]; V = signed overflow for ADD (A, B same sign, result sign differs), V=0 for AND/MVN.
REQ-026 MOV SHALL NOT change status.
REQ-027 WRITE: rf_write=1, rf_writenum=latched rd, rf_data_in=imm (MOV) or C (others); rf_write=0 and rf_writenum=0 in every other state.
REQ-028 rf_data_in SHALL hold last driven value outside WRITE.
REQ-029 done SHALL be registered, high exactly one cycle, the cycle after WRITE.
REQ-030 Latency, accept edge to write edge: MOV 1, MVN 3, ADD/AND 4 cycles.
REQ-031 Back-to-back: command accepted in the done cycle SHALL be legal; throughput one command per (latency+1) cycles.
REQ-032 rd equal to rn or rm SHALL be legal; sources read before write.
REQ-033 cmd_valid deasserted in IDLE: state holds, no outputs change.

Reset
REQ-034 reset_n=0 SHALL asynchronously force IDLE, A=B=C=0, status=000, done=0, rf_write=0, rf_readnum=rf_writenum=0, rf_data_in=0.
REQ-035 Reset mid-operation SHALL abort the command with no register write and no done pulse.
REQ-036 First command accepted on first rising edge with reset_n=1 and cmd_valid=1.

Verification
REQ-037 MOV R3, 0x0042 -> rf_write=1 with writenum=3, data 0x0042 one cycle after accept; done next cycle; status unchanged.
REQ-038 R1=0x7FFF, R2=0x0001, ADD R0,R1,R2 -> readnum 1 then 2, write R0=0x8000 at accept+4, status N=1 V=1 Z=0.
REQ-039 R4=0x00FF, R5=0xFF00, AND R6,R4,R5 -> R6=0x0000, Z=1 N=0 V=0.
REQ-040 R7=0x0000, MVN R7,-,R7 -> LOAD_A skipped, R7=0xFFFF at accept+3, N=1 Z=0.
REQ-041 ADD accepted, reset_n pulsed low during EXEC -> no rf_write, no done, outputs at reset values, cmd_ready=1 after release.
REQ-042 Two MOVs, second held valid from the done cycle -> accepted in the done cycle, both writes occur, cmd_ready low while busy.
